// File: rtl/fixpoint_iter_ctrl.sv
// rtl/fixpoint_iter_ctrl.sv - bounded fixpoint iteration sequencer for a step/check datapath
module fixpoint_iter_ctrl #(
    parameter  int WIDTH    = 30,
    parameter  int MAX_ITER = 10,
    parameter  int SETTLE   = 1,
    localparam int IW       = $clog2(MAX_ITER + 1),
    localparam int CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] init_i,
    output logic [WIDTH-1:0] cur_o,
    output logic             eval_o,
    input  logic [WIDTH-1:0] nxt_i,
    input  logic             chk_i,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result,
    output logic [IW-1:0]    iter_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] R_NONE  = 2'b00;
    localparam logic [1:0] R_PASS  = 2'b01;
    localparam logic [1:0] R_FAIL  = 2'b10;
    localparam logic [1:0] R_BOUND = 2'b11;

    state_t          state;
    logic [CW-1:0]   settle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_o      <= '0;
            eval_o     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= R_NONE;
            iter_o     <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_o      <= init_i;
                        iter_o     <= '0;
                        result     <= R_NONE;
                        settle_cnt <= CW'(SETTLE - 1);
                        eval_o     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // Abort beats any verdict, even one landing on the same cycle.
                    if (abort) begin
                        result <= R_NONE;
                        eval_o <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end else if (!chk_i || (nxt_i == cur_o) || (iter_o == IW'(MAX_ITER))) begin
                        if (!chk_i)
                            result <= R_FAIL;
                        else if (nxt_i == cur_o)
                            result <= R_PASS;
                        else
                            result <= R_BOUND;
                        eval_o <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        cur_o      <= nxt_i;
                        iter_o     <= iter_o + IW'(1);
                        settle_cnt <= CW'(SETTLE - 1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    eval_o <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
